// File: rtl/handshake_sink_checker_pkg.sv
// Shared definitions for sink-side handshake units.
// Contents:
//   sink_state_e  - run-control FSM encoding (idle / run / done), shared by all
//                   sink-side checkers so their state is observed uniformly.
package handshake_sink_checker_pkg;

   localparam int unsigned SinkStateBits = 2;

   typedef enum logic [SinkStateBits-1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } sink_state_e;

endpackage

// File: rtl/handshake_sink_checker_if.sv
// Valid/ready data channel feeding a sink.
// Signals:
//   ins        - data token (DATA_WIDTH bits), driven by the source
//   ins_valid  - token present, driven by the source
//   ins_ready  - sink accepts the token, driven by the sink
// Modports: master (source side), slave (sink side).
interface handshake_sink_checker_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;

   modport master (
      output ins,
      output ins_valid,
      input  ins_ready
   );

   modport slave (
      input  ins,
      input  ins_valid,
      output ins_ready
   );

endinterface

// File: rtl/handshake_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count on the next edge (wins over inc)
//   inc       - add one on the next edge unless already at all-ones
//   count     - registered count value
module handshake_sat_counter #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/handshake_sink_checker.sv
// Consumes NUM_TOKENS tokens per run from a valid/ready channel and checks each
// against a fixed EXPECTED value.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   bus (slave)      - ins / ins_valid in, ins_ready out (ready only while running)
//   start            - pulse that begins a run from idle or done (ignored while running)
//   done             - high exactly while the run has finished
//   match_count      - tokens equal to EXPECTED in this run
//   mismatch_count   - tokens differing from EXPECTED in this run
//   first_bad        - value of the first mismatching token of the run
//   first_bad_valid  - first_bad holds a captured value
module handshake_sink_checker
   import handshake_sink_checker_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH = 32,
   parameter longint unsigned EXPECTED   = 950,
   parameter int unsigned     NUM_TOKENS = 16,
   parameter int unsigned     CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   handshake_sink_checker_if.slave     bus,
   input  logic                        start,
   output logic                        done,
   output logic [CNT_WIDTH-1:0]        match_count,
   output logic [CNT_WIDTH-1:0]        mismatch_count,
   output logic [DATA_WIDTH-1:0]       first_bad,
   output logic                        first_bad_valid
);

   localparam longint unsigned CntMax =
      (CNT_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_WIDTH) - 64'd1);
   localparam logic [DATA_WIDTH-1:0] ExpectedVal = DATA_WIDTH'(EXPECTED);
   localparam logic [CNT_WIDTH-1:0]  LastIndex   = CNT_WIDTH'(NUM_TOKENS - 1);

   // A run length the token counter cannot represent is a configuration error.
   if ((NUM_TOKENS < 1) || (64'(NUM_TOKENS) > CntMax)) begin : gen_bad_num_tokens
      $error("NUM_TOKENS must lie in 1 .. 2**CNT_WIDTH-1");
   end

   sink_state_e           state_q;
   logic                  ready_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] first_bad_q;
   logic                  first_bad_valid_q;

   logic                  xfer;
   logic                  is_match;
   logic                  last_xfer;
   logic                  clear_run;
   logic [CNT_WIDTH-1:0]  tok_count;

   // ready_q mirrors "state is run", so ins_valid never reaches ins_ready.
   assign xfer      = bus.ins_valid && ready_q;
   assign is_match  = (bus.ins == ExpectedVal);
   assign last_xfer = xfer && (tok_count == LastIndex);
   assign clear_run = start && (state_q != StRun);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= StIdle;
         ready_q           <= 1'b0;
         done_q            <= 1'b0;
         first_bad_q       <= '0;
         first_bad_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q           <= StRun;
                  ready_q           <= 1'b1;
                  done_q            <= 1'b0;
                  first_bad_q       <= '0;
                  first_bad_valid_q <= 1'b0;
               end
            end
            StRun: begin
               if (xfer) begin
                  if (!is_match && !first_bad_valid_q) begin
                     first_bad_q       <= bus.ins;
                     first_bad_valid_q <= 1'b1;
                  end
                  // Leave run on the final transfer so no extra token is taken.
                  if (last_xfer) begin
                     state_q <= StDone;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   handshake_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_tok_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_run),
      .inc   (xfer),
      .count (tok_count)
   );

   handshake_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_run),
      .inc   (xfer && is_match),
      .count (match_count)
   );

   handshake_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_mismatch_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_run),
      .inc   (xfer && !is_match),
      .count (mismatch_count)
   );

   assign bus.ins_ready   = ready_q;
   assign done            = done_q;
   assign first_bad       = first_bad_q;
   assign first_bad_valid = first_bad_valid_q;

endmodule

// File: doc/handshake_sink_checker.md
HANDSHAKE_SINK_CHECKER -- requirements
Module: handshake_sink_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the consumed data channel.
REQ-002 Parameter EXPECTED, default 950 (10'b1110110110 zero-extended): value every token is compared against.
REQ-003 Parameter NUM_TOKENS, default 16, legal range 1..2^CNT_WIDTH-1: tokens consumed per run.
REQ-004 Parameter CNT_WIDTH, default 16: width of all counters.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-006 Ports:
  clk  input  1  clock.
  rst  input  1  asynchronous active-high reset.
  ins  input  DATA_WIDTH  consumed data token.
  ins_valid  input  1  token present.
  ins_ready  output  1  sink accepts the token.
  start  input  1  single-cycle pulse that begins a run.
  done  output  1  run complete.
  match_count  output  CNT_WIDTH  tokens equal to EXPECTED.
  mismatch_count  output  CNT_WIDTH  tokens differing from EXPECTED.
  first_bad  output  DATA_WIDTH  value of the first mismatching token in the run.
  first_bad_valid  output  1  first_bad holds a captured value.

Function
REQ-007 An FSM SHALL have states IDLE, RUN and DONE.
REQ-008 A transfer SHALL occur on a rising clk edge where ins_valid and ins_ready are both 1.
REQ-009 ins_ready SHALL be 1 only in RUN, driven from state registers only, with no combinational path from ins_valid.
REQ-010 IDLE SHALL go to RUN on start=1 and clear all counters, first_bad and first_bad_valid on that same edge.
REQ-011 DONE SHALL go to RUN on start=1 with the same clearing as REQ-010.
REQ-012 In DONE without start, counters and first_bad SHALL hold.
REQ-013 start SHALL be ignored in RUN.
REQ-014 Each transfer SHALL increment match_count if ins==EXPECTED, else increment mismatch_count.
REQ-015 Outputs SHALL be visible one cycle after the transfer edge.
REQ-016 The first mismatching transfer of a run SHALL load first_bad and set first_bad_valid.
REQ-017 Later mismatches SHALL NOT change first_bad.
REQ-018 A tokens-consumed counter SHALL track transfers in the run.
REQ-019 On the transfer that makes the count equal NUM_TOKENS, the FSM SHALL move to RUN->DONE on that same edge, so ins_ready=0 from the next cycle.
REQ-020 No extra token SHALL be accepted after the last one.
REQ-021 done SHALL equal 1 exactly while in DONE, registered.
REQ-022 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-023 EXPECTED SHALL be truncated/zero-extended to DATA_WIDTH before comparison.
REQ-024 ins_valid=1 outside RUN SHALL cause no state change; the token stays pending upstream.
REQ-025 A valid token may be held with ready low; no data capture SHALL occur without a transfer.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, ins_ready=0, done=0, all counters 0, first_bad=0 and first_bad_valid=0, independent of clk.
REQ-027 Reset asserted mid-run SHALL discard the run; after deassertion the block SHALL wait in IDLE for start.
REQ-028 Deassertion SHALL take effect on the next clk edge.

Structure
REQ-029 The FSM state encoding SHALL be defined as a shared localparam/typedef set in the common handshake package, reused by other sink-side units.
REQ-030 A natural sub-module is handshake_sat_counter (CNT_WIDTH, clear, inc, saturating), instantiated three times.
REQ-031 All other logic SHALL stay in a single module.

Verification
REQ-032 Reset, start, then 16 tokens of 950 with ins_valid always 1 -> 16 transfers on consecutive cycles; match_count=16, mismatch_count=0, done=1; ins_ready=0 the cycle after the 16th.
REQ-033 Run with tokens 950,5,950,7, rest 950 -> mismatch_count=2, match_count=14, first_bad=5, first_bad_valid=1.
REQ-034 ins_valid toggling 1/0 every cycle during RUN -> exactly 16 transfers total, done after 32 cycles, no double counting.
REQ-035 Assert rst asynchronously after 8 transfers -> all outputs 0 immediately with no clk edge; start then restarts the count from 0.
REQ-036 Start in DONE with ins_valid held 1 -> counters cleared, new run of 16; a start pulse during RUN -> no effect on counts.
REQ-037 CNT_WIDTH=3, NUM_TOKENS=7, all mismatches -> mismatch_count=7 with no wrap; then force 9 via a NUM_TOKENS=7/CNT_WIDTH=2 illegal config check -> elaboration error.
